// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple-carry slice, one nibble per cycle, LSB first.
// The 4-bit slice module lives alongside the top so the design stays a single file.

module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic [3:0] Cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = c[4:1];

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned CntW = (Nib + 1 > 1) ? $clog2(Nib + 1) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [3:0]        slice_s;
  logic [3:0]        slice_c;
  logic [WIDTH-1:0]  acc_shift;
  logic              unused_c;

  ripple_carry_adder u_slice (
    .A    (a_sh_q[3:0]),
    .B    (b_sh_q[3:0]),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_c)
  );

  // Only the nibble carry-out is needed; the inner ripple carries are dropped.
  assign unused_c = ^slice_c[2:0];

  if (WIDTH > 4) begin : g_wide
    assign acc_shift = {slice_s, acc_q[WIDTH-1:4]};
  end else begin : g_narrow
    assign acc_shift = slice_s;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        acc_d   = acc_shift;
        carry_d = slice_c[3];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Nib - 1)) begin
          // Result registers load only here, so they stay stable throughout DONE.
          sum_d   = acc_shift;
          cout_d  = slice_c[3];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed operands, expected {cout,sum} queued at
// accept and checked by a monitor at each output handshake.

module tb_nibble_serial_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int handshakes = 0;
  logic [W:0] sb_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      handshakes++;
      if (sb_q.size() == 0) begin
        check("unexpected_result", {15'd0, cout, sum}, 32'hDEAD);
      end else begin
        logic [W:0] exp;
        exp = sb_q.pop_front();
        check("result", {15'd0, cout, sum}, {15'd0, exp});
      end
    end
  end

  // Present operands at posedge+1 and return just after the accept edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input bit push);
    bit ok;
    ok = 1'b0;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) sb_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv});
  endtask

  // Count edges from accept until out_valid, then wait for the handshake if out_ready is high.
  task automatic wait_result(input bit check_lat, input bit drain);
    int k;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (out_valid) break;
    end
    if (!out_valid) check("done_timeout", 32'd0, 32'd1);
    else if (check_lat) check("latency", k, 4);
    if (drain) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (!out_valid) break;
      end
      check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reach DONE with a stalled consumer, then reset there.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_result(1'b0, 1'b0);
    check("pre_reset_sum", {16'd0, sum}, 32'h2345);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'h0000);
    check("rst_cout", {31'd0, cout}, 32'd0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b1);
    wait_result(1'b1, 1'b1);
    @(negedge clk);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    send(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    wait_result(1'b1, 1'b1);
    send(16'hBEEF, 16'h1234, 1'b0, 1'b1);
    wait_result(1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 1'b1);
    wait_result(1'b1, 1'b1);

    // Backpressure with in_valid toggling against a busy block.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b1);
    wait_result(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
      @(negedge clk);
      check("bp_sum", {16'd0, sum}, 32'h3333);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_hs_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_bp_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_bp_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb_q.push_back({1'b1, 16'h0000});
    @(negedge clk);
    check("post_bp_accept_busy", {31'd0, busy}, 32'd1);
    wait_result(1'b0, 1'b1);

    // Reset after two nibble edges; that result must never appear.
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrun_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_busy", {31'd0, busy}, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrun_no_out_valid", seen, 0);
    end
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b1);
    wait_result(1'b1, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    check("handshake_count", handshakes, 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
